// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and small helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
   localparam int          STEPS          = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
      return (sgn & v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: 32 shift-add multiply steps or 32 restoring divide steps.
// done is high during the final step; res_hi/res_lo then carry the finished result.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int ITER_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_div,
   input  logic        step,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [31:0]       acc_hi;
   logic [31:0]       acc_lo;
   logic [31:0]       opnd;
   logic              div_mode;
   logic [ITER_W-1:0] cnt;

   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic [31:0] div_diff;
   logic        div_ge;

   // Multiply: acc_lo starts as the multiplier and is shifted out as the product low word.
   // Divide: acc_lo starts as the dividend and collects quotient bits; acc_hi is the remainder.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
      div_sh   = {acc_hi, acc_lo[31]};
      div_ge   = (div_sh >= {1'b0, opnd});
      div_diff = div_sh[31:0] - opnd;
      if (div_mode) begin
         res_hi = div_ge ? div_diff : div_sh[31:0];
         res_lo = {acc_lo[30:0], div_ge};
      end else begin
         res_hi = mul_sum[32:1];
         res_lo = {mul_sum[0], acc_lo[31:1]};
      end
   end

   assign done = step & (cnt == ITER_W'(STEPS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         acc_hi   <= '0;
         acc_lo   <= is_div ? a : b;
         opnd     <= is_div ? b : a;
         div_mode <= is_div;
         cnt      <= '0;
      end else if (step) begin
         acc_hi   <= res_hi;
         acc_lo   <= res_lo;
         cnt      <= cnt + ITER_W'(1);
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage MULT/DIV unit with HI/LO, stall request and MFHI/MFLO/MTHI/MTLO paths.
// Build option EX_MULDIV_FAST_MUL_EN: single-cycle multiply; divide stays iterative.
//
// state   | meaning
// IDLE    | accept md op, or serve MTHI/MTLO
// MUL     | 32 shift-add steps
// DIV     | 32 restoring divide steps
// DONE    | result in HI/LO, stall released so the op leaves EX
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int ITER_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [5:0]  ex_opcode,
   input  logic [5:0]  ex_func,
   input  logic [31:0] ex_rdata_a,
   input  logic [31:0] ex_rdata_b,
   input  logic        flush,
   output logic        stall_req,
   output logic [31:0] mf_result,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   state_t state;
   logic   neg_q, neg_r, b_zero;

   logic        is_special, op_mul, op_div, op_md, is_signed;
   logic        start, step, done;
   logic [31:0] a_abs, b_abs, res_hi, res_lo, q_fix, r_fix;
   logic [63:0] prod_fix;

   assign is_special = ex_valid & (ex_opcode == OP_SPECIAL);
   assign op_mul     = is_special & ((ex_func == FUNC_MULT) | (ex_func == FUNC_MULTU));
   assign op_div     = is_special & ((ex_func == FUNC_DIV)  | (ex_func == FUNC_DIVU));
   assign op_md      = op_mul | op_div;
   assign is_signed  = (ex_func == FUNC_MULT) | (ex_func == FUNC_DIV);
   assign a_abs      = abs_if(ex_rdata_a, is_signed);
   assign b_abs      = abs_if(ex_rdata_b, is_signed);

`ifdef EX_MULDIV_FAST_MUL_EN
   logic [63:0] fast_a, fast_b, fast_p;
   // Low 64 bits of a sign/zero-extended product equal the 33x33 signed product.
   assign fast_a = {{32{is_signed & ex_rdata_a[31]}}, ex_rdata_a};
   assign fast_b = {{32{is_signed & ex_rdata_b[31]}}, ex_rdata_b};
   assign fast_p = fast_a * fast_b;
   assign start  = (state == ST_IDLE) & op_div & ~flush;
`else
   assign start  = (state == ST_IDLE) & op_md & ~flush;
`endif

   assign step = ((state == ST_MUL) | (state == ST_DIV)) & ~flush;

   muldiv_iter #(.ITER_W(ITER_W)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .is_div (op_div),
      .step   (step),
      .a      (a_abs),
      .b      (b_abs),
      .done   (done),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   assign prod_fix = neg_q ? (~{res_hi, res_lo} + 64'd1) : {res_hi, res_lo};
   assign q_fix    = neg_q ? (~res_lo + 32'd1) : res_lo;
   assign r_fix    = neg_r ? (~res_hi + 32'd1) : res_hi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         hi     <= '0;
         lo     <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else if (flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (op_md) begin
                  neg_q  <= is_signed & (ex_rdata_a[31] ^ ex_rdata_b[31]);
                  neg_r  <= is_signed & ex_rdata_a[31];
                  b_zero <= (ex_rdata_b == 32'd0);
`ifdef EX_MULDIV_FAST_MUL_EN
                  if (op_mul) begin
                     hi    <= fast_p[63:32];
                     lo    <= fast_p[31:0];
                     state <= ST_DONE;
                  end else begin
                     state <= ST_DIV;
                  end
`else
                  state <= op_div ? ST_DIV : ST_MUL;
`endif
               end else if (is_special & (ex_func == FUNC_MTHI)) begin
                  hi <= ex_rdata_a;
               end else if (is_special & (ex_func == FUNC_MTLO)) begin
                  lo <= ex_rdata_a;
               end
            end
            ST_MUL: begin
               if (done) begin
                  hi    <= prod_fix[63:32];
                  lo    <= prod_fix[31:0];
                  state <= ST_DONE;
               end
            end
            ST_DIV: begin
               if (done) begin
                  hi    <= r_fix;
                  lo    <= b_zero ? DIV_BY_ZERO_LO : q_fix;
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state == ST_MUL) | (state == ST_DIV);
   assign stall_req = ((state == ST_IDLE) & op_md) | busy;
   assign mf_result = (is_special & (ex_func == FUNC_MFHI)) ? hi :
                      (is_special & (ex_func == FUNC_MFLO)) ? lo : 32'd0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
   import muldiv_pkg::*;

`ifdef EX_MULDIV_FAST_MUL_EN
   localparam int MUL_STALL = 1;
`else
   localparam int MUL_STALL = 33;
`endif
   localparam int DIV_STALL = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [5:0]  ex_opcode;
   logic [5:0]  ex_func;
   logic [31:0] ex_rdata_a;
   logic [31:0] ex_rdata_b;
   logic        flush;
   logic        stall_req;
   logic [31:0] mf_result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_hi   = 32'd0;
   logic [31:0] exp_lo   = 32'd0;

   ex_muldiv dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_opcode  (ex_opcode),
      .ex_func    (ex_func),
      .ex_rdata_a (ex_rdata_a),
      .ex_rdata_b (ex_rdata_b),
      .flush      (flush),
      .stall_req  (stall_req),
      .mf_result  (mf_result),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      ex_valid   = v;
      ex_opcode  = OP_SPECIAL;
      ex_func    = f;
      ex_rdata_a = a;
      ex_rdata_b = b;
   endtask

   // {HI, LO} from plain integer arithmetic.
   function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         FUNC_MULT: begin p = 64'(sa * sb); return p; end
         FUNC_MULTU: return ua * ub;
         FUNC_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      int          cnt;
      int          exp_stall;
      logic [63:0] r;
      @(negedge clk);
      drive(1'b1, f, a, b);
      #1;
      cnt = 0;
      while (stall_req === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == 5) check_val("busy_mid", busy, 1);
         @(negedge clk);
         #1;
      end
      if (cnt >= 100) check_val("stall_timeout", cnt, 0);
      r         = ref_md(f, a, b);
      exp_hi    = r[63:32];
      exp_lo    = r[31:0];
      exp_stall = (f == FUNC_MULT || f == FUNC_MULTU) ? MUL_STALL : DIV_STALL;
      check_val("stall_cycles", cnt, exp_stall);
      check_val("hi", hi, exp_hi);
      check_val("lo", lo, exp_lo);
      check_val("busy_done", busy, 0);
   endtask

   task automatic flush_div_at(input int n, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive(1'b1, FUNC_DIV, a, b);
      repeat (n) @(negedge clk);
      drive(1'b0, FUNC_DIV, a, b);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check_val("flush_busy", busy, 0);
      check_val("flush_stall", stall_req, 0);
      check_val("flush_hi", hi, exp_hi);
      check_val("flush_lo", lo, exp_lo);
   endtask

   initial begin
      logic [5:0]  f;
      logic [31:0] a, b;
      rst   = 1'b1;
      flush = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      #1;
      check_val("rst_hi", hi, 0);
      check_val("rst_lo", lo, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_stall", stall_req, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_md(FUNC_DIVU, 32'd100, 32'd7);
      @(negedge clk);
      drive(1'b1, FUNC_MFHI, 32'd0, 32'd0);
      #1;
      check_val("mfhi_after_div", mf_result, exp_hi);
      check_val("mfhi_stall", stall_req, 0);

      run_md(FUNC_DIV,   32'hFFFF_FFF9, 32'd2);
      run_md(FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_md(FUNC_DIVU,  32'd5,         32'd0);
      run_md(FUNC_DIV,   32'hFFFF_FFFB, 32'd0);
      run_md(FUNC_MULT,  32'hFFFF_FFFF, 32'd3);
      run_md(FUNC_MULTU, 32'hFFFF_FFFF, 32'd3);

      @(negedge clk);
      drive(1'b1, FUNC_MTLO, 32'h0000_1234, 32'd0);
      #1;
      check_val("mtlo_stall", stall_req, 0);
      exp_lo = 32'h0000_1234;
      @(negedge clk);
      drive(1'b1, FUNC_MTHI, 32'h0000_ABCD, 32'd0);
      #1;
      check_val("mflo_after_mtlo_lo", lo, exp_lo);
      exp_hi = 32'h0000_ABCD;
      @(negedge clk);
      drive(1'b1, FUNC_MFLO, 32'd0, 32'd0);
      #1;
      check_val("mflo", mf_result, exp_lo);
      check_val("mflo_stall", stall_req, 0);
      @(negedge clk);
      drive(1'b0, FUNC_MFHI, 32'd0, 32'd0);
      #1;
      check_val("mf_bubble", mf_result, 0);
      check_val("mthi_hi", hi, exp_hi);

      for (int i = 0; i < 24; i++) begin
         f = FUNC_MULT + 6'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 255);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         run_md(f, a, b);
      end

      flush_div_at(10, 32'd1000, 32'd3);
      flush_div_at(32, 32'hFFFF_0000, 32'd17);
      run_md(FUNC_DIVU, 32'd77, 32'd10);

      @(negedge clk);
      drive(1'b1, FUNC_DIVU, 32'd12345, 32'd11);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("arst_hi", hi, 0);
      check_val("arst_lo", lo, 0);
      check_val("arst_busy", busy, 0);
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_md(FUNC_MULT, 32'h8000_0000, 32'h8000_0000);
      run_md(FUNC_DIV, 32'd7, 32'hFFFF_FFFE);

      @(negedge clk);
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
